// File: rtl/placement_driver_if.sv
// Request/placer/response bundle for placement_driver.
// master: the side that offers requests and plays the placer (drives
//         req_*_i, index_*_i, strike_i; observes everything else).
// slave:  placement_driver itself.
// Signals:
//   req_valid_i/req_height_i/req_width_i/req_ready_o  request handshake
//   height_o/width_o                                  dimensions to placer
//   index_x_i/index_y_i/strike_i                      placer results
//   rsp_valid_o/rsp_*_o                               one-cycle response
//   drop_cnt_o                                        zero-dimension drops
//   busy_o                                            work queued or in flight
interface placement_driver_if;
  logic       req_valid_i;
  logic [4:0] req_height_i;
  logic [4:0] req_width_i;
  logic       req_ready_o;
  logic [4:0] height_o;
  logic [4:0] width_o;
  logic [7:0] index_x_i;
  logic [7:0] index_y_i;
  logic [3:0] strike_i;
  logic       rsp_valid_o;
  logic [4:0] rsp_height_o;
  logic [4:0] rsp_width_o;
  logic [7:0] rsp_x_o;
  logic [7:0] rsp_y_o;
  logic [3:0] rsp_strike_o;
  logic [7:0] drop_cnt_o;
  logic       busy_o;

  modport master (
    output req_valid_i, req_height_i, req_width_i, index_x_i, index_y_i, strike_i,
    input  req_ready_o, height_o, width_o, rsp_valid_o, rsp_height_o, rsp_width_o,
           rsp_x_o, rsp_y_o, rsp_strike_o, drop_cnt_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_height_i, req_width_i, index_x_i, index_y_i, strike_i,
    output req_ready_o, height_o, width_o, rsp_valid_o, rsp_height_o, rsp_width_o,
           rsp_x_o, rsp_y_o, rsp_strike_o, drop_cnt_o, busy_o
  );
endinterface

// File: rtl/placement_driver.sv
// placement_driver: queues sticker placement requests in a small FIFO and
// feeds them to a fixed-latency placer in 4-cycle slots. Each issued request
// is tracked through a LAT_SLOTS-deep shift register; its placer result is
// sampled at phase SAMPLE_PH of slot n+LAT_SLOTS and returned as a one-cycle
// response. Zero-dimension requests are accepted, discarded and counted.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous reset, active low
//   bus  placement_driver_if.slave (request, placer and response signals)
module placement_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LAT_SLOTS  = 2,
  parameter int unsigned SAMPLE_PH  = 3
) (
  input  logic               clk,
  input  logic               rst,
  placement_driver_if.slave  bus
);

  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0]  SMP_PH = 2'(SAMPLE_PH);

  // OFF: in reset. ARM: first cycle after release, ready but no slot yet.
  // RUN: slots running; the ARM->RUN edge is the start of slot 0.
  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ARM = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;

  logic [1:0]    state;
  logic [1:0]    phase;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic                 cur_v;
  logic [LAT_SLOTS-1:0] sr_v;
  logic [4:0]           sr_h [LAT_SLOTS];
  logic [4:0]           sr_w [LAT_SLOTS];

  logic fifo_full;
  logic req_fire;
  logic req_zero;
  logic push;
  logic pop;
  logic slot_start;
  logic smp_now;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign req_zero   = (bus.req_height_i == '0) || (bus.req_width_i == '0);
  assign req_fire   = bus.req_valid_i && bus.req_ready_o;
  assign push       = req_fire && !req_zero;
  // Registered count gives the one-cycle minimum residency before issue.
  assign pop        = slot_start && (count != '0);
  assign slot_start = (state == ST_ARM) || ((state == ST_RUN) && (phase == 2'd3));
  assign smp_now    = (state == ST_RUN) && (phase == SMP_PH);

  assign bus.req_ready_o = (state != ST_OFF) && !fifo_full;
  assign bus.busy_o      = (count != '0) || cur_v || (|sr_v);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.req_height_i, bus.req_width_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_OFF;
      phase            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      cur_v            <= 1'b0;
      bus.height_o     <= '0;
      bus.width_o      <= '0;
      sr_v             <= '0;
      for (int unsigned i = 0; i < LAT_SLOTS; i++) begin
        sr_h[i] <= '0;
        sr_w[i] <= '0;
      end
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_height_o <= '0;
      bus.rsp_width_o  <= '0;
      bus.rsp_x_o      <= '0;
      bus.rsp_y_o      <= '0;
      bus.rsp_strike_o <= '0;
      bus.drop_cnt_o   <= '0;
    end else begin
      case (state)
        ST_OFF:  state <= ST_ARM;
        ST_ARM:  state <= ST_RUN;
        default: phase <= phase + 2'd1;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      if (slot_start) begin
        cur_v        <= pop;
        bus.height_o <= pop ? mem[rd_ptr][9:5] : '0;
        bus.width_o  <= pop ? mem[rd_ptr][4:0] : '0;
        sr_v[0]      <= cur_v;
        sr_h[0]      <= bus.height_o;
        sr_w[0]      <= bus.width_o;
        for (int unsigned i = 1; i < LAT_SLOTS; i++) begin
          sr_v[i] <= sr_v[i-1];
          sr_h[i] <= sr_h[i-1];
          sr_w[i] <= sr_w[i-1];
        end
      end

      if (req_fire && req_zero && (bus.drop_cnt_o != '1)) begin
        bus.drop_cnt_o <= bus.drop_cnt_o + 8'd1;
      end

      // Oldest entry is sampled before this edge's shift moves it out.
      bus.rsp_valid_o <= smp_now && sr_v[LAT_SLOTS-1];
      if (smp_now && sr_v[LAT_SLOTS-1]) begin
        bus.rsp_height_o <= sr_h[LAT_SLOTS-1];
        bus.rsp_width_o  <= sr_w[LAT_SLOTS-1];
        bus.rsp_x_o      <= bus.index_x_i;
        bus.rsp_y_o      <= bus.index_y_i;
        bus.rsp_strike_o <= bus.strike_i;
      end
    end
  end

endmodule
